// File: rtl/pb_pkg.sv
// rtl/pb_pkg.sv - shared types and constants for the pushbutton up/down decoder
// Holds the press/chord FSM state type, the button bit positions within PB,
// and the helper that derives the LEVEL reset (mid) value from its width.
package pb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    CHORD  = 2'd3
  } pb_state_e;

  localparam int PB_UP = 1;
  localparam int PB_DN = 0;

  // Mid-scale rate index: 2^(level_w-1).
  function automatic int level_mid(input int level_w);
    return 1 << (level_w - 1);
  endfunction

endpackage

// File: rtl/pb_debounce.sv
// rtl/pb_debounce.sv - one-bit two-flop synchroniser plus debounce counter
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset (debounce state only)
//   pb_raw     in   raw asynchronous button level
//   sync_level out  synchronised (not debounced) button level
//   stable     out  debounced button level
module pb_debounce #(
  parameter int DEBOUNCE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_raw,
  output logic sync_level,
  output logic stable
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             meta_q;
  logic             sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;

  // The synchroniser is deliberately not reset so that it keeps tracking the
  // physical button through a reset; the decoder relies on that to recognise
  // a press that was already in progress when reset released.
  always_ff @(posedge clk) begin
    meta_q <= pb_raw;
    sync_q <= meta_q;
  end

  // Count cycles of disagreement; the level is accepted on the cycle the count
  // has already reached DEBOUNCE_CYCLES, so DEBOUNCE_CYCLES+1 consecutive
  // disagreeing samples are needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else if (sync_q == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_MAX) begin
      stable_q <= ~stable_q;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign sync_level = sync_q;
  assign stable     = stable_q;

endmodule

// File: rtl/pb_updown_decoder.sv
// rtl/pb_updown_decoder.sv - pushbutton conditioner producing up/down/clear pulses and a rate level
// Optional feature macro: PB_AUTO_REPEAT_EN (auto-repeat while a button is held).
// Ports:
//   OSC_FPGA    in   system clock, rising edge
//   RESET_N     in   asynchronous active-low reset
//   PB[1:0]     in   raw buttons, active-high; PB[1]=UP, PB[0]=DOWN
//   UP_PULSE    out  one-cycle up command
//   DOWN_PULSE  out  one-cycle down command
//   CLEAR_PULSE out  one-cycle chord command
//   LEVEL       out  saturating rate index, reset to mid-scale
//   PB_STABLE   out  debounced button levels
module pb_updown_decoder
  import pb_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int REPEAT_DELAY    = 32,
  parameter int REPEAT_PERIOD   = 8,
  parameter int LEVEL_W         = 3
) (
  input  logic               OSC_FPGA,
  input  logic               RESET_N,
  input  logic [1:0]         PB,
  output logic               UP_PULSE,
  output logic               DOWN_PULSE,
  output logic               CLEAR_PULSE,
  output logic [LEVEL_W-1:0] LEVEL,
  output logic [1:0]         PB_STABLE
);

  localparam logic [LEVEL_W-1:0] LEVEL_MID = LEVEL_W'(level_mid(LEVEL_W));
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = {LEVEL_W{1'b1}};

  logic [1:0]         sync_level;
  logic [1:0]         stable;
  logic [1:0]         stable_d_q;
  logic [1:0]         lock_q;
  logic [1:0]         rise;
  pb_state_e          state_q, state_d;
  logic               dir_q, dir_d;
  logic               up_d, dn_d, clr_d;
  logic               other_rise;
  logic               held_level;
  logic [LEVEL_W-1:0] level_d;

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk        (OSC_FPGA),
    .rst_n      (RESET_N),
    .pb_raw     (PB[PB_UP]),
    .sync_level (sync_level[PB_UP]),
    .stable     (stable[PB_UP])
  );

  pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
    .clk        (OSC_FPGA),
    .rst_n      (RESET_N),
    .pb_raw     (PB[PB_DN]),
    .sync_level (sync_level[PB_DN]),
    .stable     (stable[PB_DN])
  );

  // A button stays locked out after reset until it has been seen released, so
  // a press already held across reset never produces a command.
  always_ff @(posedge OSC_FPGA or negedge RESET_N) begin
    if (!RESET_N) begin
      stable_d_q <= 2'b00;
      lock_q     <= 2'b11;
    end else begin
      stable_d_q <= stable;
      lock_q     <= lock_q & sync_level;
    end
  end

  assign rise       = stable & ~stable_d_q & ~lock_q;
  assign other_rise = dir_q ? rise[PB_DN] : rise[PB_UP];
  assign held_level = dir_q ? stable[PB_UP] : stable[PB_DN];

`ifdef PB_AUTO_REPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             rpt_due;

  assign rpt_due = (state_q == HOLD) ? (rpt_q == RPT_DELAY_LAST)
                                     : (rpt_q == RPT_PERIOD_LAST);

  always_ff @(posedge OSC_FPGA or negedge RESET_N) begin
    if (!RESET_N) rpt_q <= '0;
    else          rpt_q <= rpt_d;
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    up_d    = 1'b0;
    dn_d    = 1'b0;
    clr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise == 2'b11) begin
          clr_d   = 1'b1;
          state_d = CHORD;
        end else if (rise[PB_UP]) begin
          up_d    = 1'b1;
          dir_d   = 1'b1;
          state_d = HOLD;
        end else if (rise[PB_DN]) begin
          dn_d    = 1'b1;
          dir_d   = 1'b0;
          state_d = HOLD;
        end
      end
      HOLD, REPEAT: begin
        // Chord beats release, release beats the repeat timer.
        if (other_rise) begin
          clr_d   = 1'b1;
          state_d = CHORD;
        end else if (!held_level) begin
          state_d = IDLE;
        end
`ifdef PB_AUTO_REPEAT_EN
        else if (rpt_due) begin
          up_d    = dir_q;
          dn_d    = ~dir_q;
          state_d = REPEAT;
        end
`endif
      end
      CHORD: begin
        if (stable == 2'b00) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef PB_AUTO_REPEAT_EN
    // Restart the timer on every state change and after every repeat pulse.
    if ((state_d == state_q) && !(up_d || dn_d) &&
        ((state_q == HOLD) || (state_q == REPEAT)))
      rpt_d = rpt_q + 1'b1;
    else
      rpt_d = '0;
`endif
  end

  always_comb begin
    level_d = LEVEL;
    if (clr_d)                             level_d = LEVEL_MID;
    else if (up_d && (LEVEL != LEVEL_MAX)) level_d = LEVEL + 1'b1;
    else if (dn_d && (LEVEL != '0))        level_d = LEVEL - 1'b1;
  end

  always_ff @(posedge OSC_FPGA or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= IDLE;
      dir_q       <= 1'b0;
      UP_PULSE    <= 1'b0;
      DOWN_PULSE  <= 1'b0;
      CLEAR_PULSE <= 1'b0;
      LEVEL       <= LEVEL_MID;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      UP_PULSE    <= up_d;
      DOWN_PULSE  <= dn_d;
      CLEAR_PULSE <= clr_d;
      LEVEL       <= level_d;
    end
  end

  assign PB_STABLE = stable;

endmodule

// File: tb/tb_pb_updown_decoder.sv
// tb/tb_pb_updown_decoder.sv - self-checking bench for pb_updown_decoder
module tb_pb_updown_decoder;

  localparam int N    = 8;
  localparam int RD   = 32;
  localparam int RP   = 8;
  localparam int LW   = 3;
  localparam int MID  = 4;
  localparam int LMAX = 7;

  logic          OSC_FPGA = 1'b0;
  logic          RESET_N  = 1'b0;
  logic [1:0]    PB       = 2'b00;
  logic          UP_PULSE, DOWN_PULSE, CLEAR_PULSE;
  logic [LW-1:0] LEVEL;
  logic [1:0]    PB_STABLE;

  pb_updown_decoder #(
    .DEBOUNCE_CYCLES (N),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP),
    .LEVEL_W         (LW)
  ) dut (
    .OSC_FPGA    (OSC_FPGA),
    .RESET_N     (RESET_N),
    .PB          (PB),
    .UP_PULSE    (UP_PULSE),
    .DOWN_PULSE  (DOWN_PULSE),
    .CLEAR_PULSE (CLEAR_PULSE),
    .LEVEL       (LEVEL),
    .PB_STABLE   (PB_STABLE)
  );

  always #5 OSC_FPGA = ~OSC_FPGA;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_up   = 0;
  int n_dn   = 0;
  int n_clr  = 0;
  int last_up_cyc = -1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: raw samples history, stable levels derived from a window rule,
  // press/chord bookkeeping and integer level arithmetic.
  logic [1:0] hist[$];
  logic [1:0] m_st      = 2'b00;
  logic [1:0] m_st_prev = 2'b00;
  logic [1:0] m_armed   = 2'b00;
  int         run_ok    = 0;
  int         m_mode    = 0;   // 0 none, 1 single button held, 2 chord
  int         m_held    = 0;
  int         m_age     = 0;
  logic       m_up = 1'b0, m_dn = 1'b0, m_clr = 1'b0;
  int         m_level   = MID;

  initial for (int k = 0; k < N + 3; k++) hist.push_back(2'b00);

  always @(posedge OSC_FPGA) begin
    logic [1:0] sync_v;
    logic [1:0] rise_v;
    logic [1:0] h;
    bit         all_diff;
    cyc++;
    hist.push_front(PB);
    void'(hist.pop_back());
    if (!RESET_N) begin
      m_st = 2'b00; m_st_prev = 2'b00; m_armed = 2'b00;
      run_ok = 0; m_mode = 0; m_age = 0;
      m_up = 1'b0; m_dn = 1'b0; m_clr = 1'b0;
      m_level = MID;
    end else begin
      run_ok++;
      sync_v = hist[2];
      rise_v = m_st & ~m_st_prev & m_armed;
      m_up = 1'b0; m_dn = 1'b0; m_clr = 1'b0;
      if (m_mode == 0) begin
        if (rise_v == 2'b11) begin
          m_clr = 1'b1; m_mode = 2;
        end else if (rise_v != 2'b00) begin
          m_held = rise_v[1] ? 1 : 0;
          if (m_held == 1) m_up = 1'b1; else m_dn = 1'b1;
          m_mode = 1; m_age = 0;
        end
      end else if (m_mode == 1) begin
        if (rise_v[1 - m_held]) begin
          m_clr = 1'b1; m_mode = 2;
        end else if (!m_st[m_held]) begin
          m_mode = 0;
        end else begin
          m_age++;
`ifdef PB_AUTO_REPEAT_EN
          if (m_age == RD || (m_age > RD && ((m_age - RD) % RP) == 0)) begin
            if (m_held == 1) m_up = 1'b1; else m_dn = 1'b1;
          end
`endif
        end
      end else begin
        if (m_st == 2'b00) m_mode = 0;
      end
      if (m_clr)                        m_level = MID;
      else if (m_up && m_level < LMAX)  m_level = m_level + 1;
      else if (m_dn && m_level > 0)     m_level = m_level - 1;
      m_armed   = m_armed | ~sync_v;
      m_st_prev = m_st;
      // A level is accepted once N+1 consecutive synchronised samples since
      // reset have disagreed with the current stable level.
      for (int i = 0; i < 2; i++) begin
        if (run_ok >= N + 1) begin
          all_diff = 1'b1;
          for (int k = 2; k <= N + 2; k++) begin
            h = hist[k];
            if (h[i] == m_st[i]) all_diff = 1'b0;
          end
          if (all_diff) m_st[i] = ~m_st[i];
        end
      end
    end
  end

  initial forever begin
    @(posedge OSC_FPGA);
    #1;
    chk("up_pulse",    int'(UP_PULSE),    int'(m_up));
    chk("down_pulse",  int'(DOWN_PULSE),  int'(m_dn));
    chk("clear_pulse", int'(CLEAR_PULSE), int'(m_clr));
    chk("level",       int'(LEVEL),       m_level);
    chk("pb_stable",   int'(PB_STABLE),   int'(m_st));
    if (UP_PULSE) begin n_up++; last_up_cyc = cyc; end
    if (DOWN_PULSE)  n_dn++;
    if (CLEAR_PULSE) n_clr++;
  end

  task automatic drive(input logic [1:0] v, input int n);
    PB = v;
    repeat (n) @(negedge OSC_FPGA);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    drive(2'b00, 3);
    RESET_N = 1'b1;
    drive(2'b00, 3);
  endtask

  int s_up, s_dn, s_clr, e0;
  int up_lv[5] = '{5, 6, 7, 7, 7};
  int dn_lv[8] = '{6, 5, 4, 3, 2, 1, 0, 0};

  initial begin
    repeat (4) @(negedge OSC_FPGA);
    chk("reset_level",  int'(LEVEL), MID);
    chk("reset_stable", int'(PB_STABLE), 0);
    chk("reset_pulses", int'(UP_PULSE) + int'(DOWN_PULSE) + int'(CLEAR_PULSE), 0);
    RESET_N = 1'b1;
    drive(2'b00, 5);

    // Glitch rejection
    s_up = n_up; s_dn = n_dn; s_clr = n_clr;
    drive(2'b10, 5);
    drive(2'b00, 20);
    chk("glitch_pulses", (n_up - s_up) + (n_dn - s_dn) + (n_clr - s_clr), 0);
    chk("glitch_stable", int'(PB_STABLE), 0);
    chk("glitch_level",  int'(LEVEL), 4);

    // Single press and latency
    s_up = n_up;
    e0 = cyc + 1;
    drive(2'b10, 20);
    chk("press_count",   n_up - s_up, 1);
    chk("press_latency", last_up_cyc - e0, 11);
    chk("press_level",   int'(LEVEL), 5);
    chk("press_stable",  int'(PB_STABLE), 2);
    drive(2'b00, 20);

    // Saturation up then down
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(2'b10, 15);
      drive(2'b00, 15);
      chk("sat_up_level", int'(LEVEL), up_lv[i]);
    end
    for (int i = 0; i < 8; i++) begin
      drive(2'b01, 15);
      drive(2'b00, 15);
      chk("sat_dn_level", int'(LEVEL), dn_lv[i]);
    end

    // Chord
    s_up = n_up; s_dn = n_dn; s_clr = n_clr;
    drive(2'b10, 15);
    chk("chord_up_count", n_up - s_up, 1);
    drive(2'b11, 15);
    chk("chord_clr_count", n_clr - s_clr, 1);
    chk("chord_level", int'(LEVEL), 4);
    drive(2'b01, 20);
    chk("chord_no_rearm", n_dn - s_dn, 0);
    drive(2'b00, 20);
    drive(2'b01, 15);
    chk("chord_dn_count", n_dn - s_dn, 1);
    chk("chord_dn_level", int'(LEVEL), 3);
    drive(2'b00, 20);

    // Reset mid-hold
    s_dn = n_dn;
    drive(2'b01, 15);
    chk("hold_dn_count", n_dn - s_dn, 1);
    RESET_N = 1'b0;
    #1;
    chk("async_rst_level",  int'(LEVEL), MID);
    chk("async_rst_stable", int'(PB_STABLE), 0);
    @(negedge OSC_FPGA);
    drive(2'b01, 2);
    RESET_N = 1'b1;
    s_dn = n_dn;
    drive(2'b01, 30);
    chk("rst_hold_no_pulse", n_dn - s_dn, 0);
    chk("rst_hold_level", int'(LEVEL), MID);
    drive(2'b00, 20);
    drive(2'b01, 15);
    chk("rst_repress_count", n_dn - s_dn, 1);
    chk("rst_repress_level", int'(LEVEL), 3);
    drive(2'b00, 20);

    // Long hold
    s_up = n_up;
    drive(2'b10, RD + RP * 3 + 10);
    drive(2'b00, 20);
`ifdef PB_AUTO_REPEAT_EN
    chk("long_hold_count", n_up - s_up, 6);
    chk("long_hold_level", int'(LEVEL), 7);
`else
    chk("long_hold_count", n_up - s_up, 1);
    chk("long_hold_level", int'(LEVEL), 4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
